if_fetch: RTL

- Instruction-fetch front end of the 5-stage MIPS pipeline, upstream of the IF/ID register.
- Owns the PC and handles redirects from branches and from flush/exception (new_pc).
- Drives a req/ack instruction-bus handshake to instruction SRAM and presents if_pc/if_inst to IF/ID.
- Requests a pipeline stall from ctrl while a fetch is outstanding.

---
 rtl/if_fetch_pkg.sv | 16 +
 rtl/if_fetch_if.sv | 10 +
 rtl/if_fetch.sv | 119 +++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch front end.
package if_fetch_pkg;

  localparam logic [31:0] ZeroWord   = '0;
  localparam logic        Stop       = 1'b1;
  localparam logic        NoStop     = 1'b0;
  localparam logic        RstEnableN = 1'b0;

  typedef enum logic [1:0] {
    IF_BOOT    = 2'b00,
    IF_WAIT    = 2'b01,
    IF_DONE    = 2'b10,
    IF_DISCARD = 2'b11
  } if_state_e;

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-bus req/ack handshake between the fetch stage and instruction SRAM.
interface if_fetch_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;

  modport master (output inst_req, inst_addr, input  inst_ack, inst_rdata);
  modport slave  (input  inst_req, inst_addr, output inst_ack, inst_rdata);
endinterface

// File: rtl/if_fetch.sv
// IF stage: owns the PC, drives the instruction-bus handshake and presents
// if_pc/if_inst to IF/ID, with branch capture and flush/discard handling.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  if_fetch_if.master  ibus,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_from_if
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        redir_v_q, redir_v_d;
  logic [31:0] redir_addr_q, redir_addr_d;
  logic [31:0] next_pc;
  logic        advance;
  logic        unused_stall_hi;

  assign unused_stall_hi = ^stall[5:1];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_d        = req_q;
    if_pc_d      = if_pc_q;
    if_inst_d    = if_inst_q;
    redir_v_d    = redir_v_q;
    redir_addr_d = redir_addr_q;
    next_pc      = redir_v_q     ? redir_addr_q :
                   branch_flag_i ? branch_target_address_i : pc_q + PC_STEP;
    advance      = (state_q == IF_DONE) && (stall[0] == NoStop);

    // A branch that cannot be consumed this cycle is parked until the next launch.
    if (branch_flag_i && !advance) begin
      redir_v_d    = 1'b1;
      redir_addr_d = branch_target_address_i;
    end

    if (flush) begin
      pc_d      = new_pc;
      redir_v_d = 1'b0;
      if_pc_d   = ZeroWord;
      if_inst_d = ZeroWord;
      req_d     = 1'b1;
      unique case (state_q)
        IF_WAIT, IF_DISCARD: state_d = ibus.inst_ack ? IF_WAIT : IF_DISCARD;
        default:             state_d = IF_WAIT;
      endcase
    end else begin
      unique case (state_q)
        IF_BOOT: begin
          req_d   = 1'b1;
          state_d = IF_WAIT;
        end
        IF_WAIT: begin
          if (ibus.inst_ack) begin
            if_inst_d = ibus.inst_rdata;
            if_pc_d   = pc_q;
            req_d     = 1'b0;
            state_d   = IF_DONE;
          end
        end
        IF_DONE: begin
          if (advance) begin
            pc_d      = next_pc;
            req_d     = 1'b1;
            redir_v_d = 1'b0;
            state_d   = IF_WAIT;
          end
        end
        IF_DISCARD: begin
          if (ibus.inst_ack) state_d = IF_WAIT;
        end
        default: state_d = IF_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnableN) begin
      state_q      <= IF_BOOT;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      if_pc_q      <= ZeroWord;
      if_inst_q    <= ZeroWord;
      redir_v_q    <= 1'b0;
      redir_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_q        <= req_d;
      if_pc_q      <= if_pc_d;
      if_inst_q    <= if_inst_d;
      redir_v_q    <= redir_v_d;
      redir_addr_q <= redir_addr_d;
    end
  end

  assign ibus.inst_req    = req_q;
  assign ibus.inst_addr   = pc_q;
  assign if_pc            = if_pc_q;
  assign if_inst          = if_inst_q;
  assign stallreq_from_if = (state_q != IF_DONE);

endmodule
